// File: rtl/jx_cond_pkg.sv
// rtl/jx_cond_pkg.sv - shared defaults and sizing helper for the J1 input conditioner
package jx_cond_pkg;

  localparam int   WIDTH_DEF          = 6;
  localparam int   DEBOUNCE_TICKS_DEF = 4;
  localparam logic RESET_LEVEL_DEF    = 1'b0;

  // Counter must hold 0..DEBOUNCE_TICKS-1; sized with one spare code so ticks=1 still gets a bit
  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/jx_debounce_bit.sv
// rtl/jx_debounce_bit.sv - one input bit: 2-flop sync, CE-tick debounce, edge pulses, sticky rise flag
module jx_debounce_bit
  import jx_cond_pkg::*;
#(
  parameter int   DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter logic RESET_BIT      = RESET_LEVEL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pend
);

  localparam int            CW       = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic          level_prev;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_BIT;
      s2 <= RESET_BIT;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Debounce: any cycle of agreement restarts the count; the level flips on the last CE tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= RESET_BIT;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (ce) begin
      if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Edge pulses are registered one cycle behind the level change; reset seeds level_prev so no pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= RESET_BIT;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      level_prev <= level;
      rise       <= level & ~level_prev;
      fall       <= ~level & level_prev;
    end
  end

  // Sticky rise flag held until a CE cycle consumes it; a new rise beats a coincident CE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (rise) begin
      pend <= 1'b1;
    end else if (ce) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/jx_input_conditioner.sv
// rtl/jx_input_conditioner.sv - conditions raw J1 header pins into clean levels, edges and pending flags
module jx_input_conditioner
  import jx_cond_pkg::*;
#(
  parameter int               WIDTH          = WIDTH_DEF,
  parameter int               DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL      = {WIDTH{RESET_LEVEL_DEF}}
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] PEND
);

  // Independent per-bit conditioners; bits share only clock, reset and the CE tick
  for (genvar n = 0; n < WIDTH; n++) begin : g_bit
    jx_debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RESET_BIT     (RESET_VAL[n])
    ) u_bit (
      .clk  (CLK),
      .rst_n(RESETN),
      .ce   (CE),
      .din  (I[n]),
      .level(O[n]),
      .rise (RISE[n]),
      .fall (FALL[n]),
      .pend (PEND[n])
    );
  end

endmodule
